// File: rtl/sb_rx_data_decoder.sv
// Sideband RX data decoder: checks a deframed 64-bit payload against the
// captured LTSM context and presents the recovered 16-bit data until acked.
// Ports: i_clk/i_rst clock and async reset; i_pkt_valid/i_pkt_has_data/
// i_payload packet in; i_state/i_sub_state/i_msg_no/i_point_sweep_test_en/
// i_point_sweep_test context; i_data_ack consumer ack; o_data_bus/
// o_data_valid/o_msg_no held result; o_overrun/o_fmt_err/o_timeout pulses.
module sb_rx_data_decoder #(
    parameter int CHECK_PAD      = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pkt_valid,
    input  logic        i_pkt_has_data,
    input  logic [63:0] i_payload,
    input  logic [3:0]  i_state,
    input  logic [3:0]  i_sub_state,
    input  logic [3:0]  i_msg_no,
    input  logic        i_point_sweep_test_en,
    input  logic [1:0]  i_point_sweep_test,
    input  logic        i_data_ack,
    output logic [15:0] o_data_bus,
    output logic        o_data_valid,
    output logic [3:0]  o_msg_no,
    output logic        o_overrun,
    output logic        o_fmt_err,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [63:0]          pay_q, pay_d;
    logic [3:0]           st_q, st_d;
    logic [3:0]           sub_q, sub_d;
    logic [3:0]           cmsg_q, cmsg_d;
    logic                 ten_q, ten_d;
    logic [1:0]           tst_q, tst_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [15:0]          data_q, data_d;
    logic [3:0]           msg_q, msg_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 fmt_q, fmt_d;
    logic                 to_q, to_d;

    logic                 pkt;
    logic                 acc;
    logic                 dec_ok;
    logic                 pad_ok;
    logic [15:0]          dec_data;
    logic [TIMEOUT_W:0]   cnt_inc;
    logic                 to_hit;

    assign pkt = i_pkt_valid & i_pkt_has_data;
    assign acc = pkt & ((state_q == S_IDLE) |
                        ((state_q == S_HOLD) & i_data_ack));

    // Extra bit so the compare cannot wrap before reaching the limit.
    assign cnt_inc = {1'b0, cnt_q} + (TIMEOUT_W + 1)'(1);
    assign to_hit  = (TIMEOUT_CYCLES != 0) &&
                     (cnt_inc == (TIMEOUT_W + 1)'(TIMEOUT_CYCLES));

    always_comb begin
        dec_ok   = 1'b0;
        pad_ok   = 1'b0;
        dec_data = 16'h0000;
        if (ten_q && cmsg_q == 4'd1) begin
            // Five data bits scattered around a 16-bit all-ones marker.
            dec_data = {11'b0, pay_q[59], pay_q[11], pay_q[7:6], pay_q[0]};
            pad_ok   = (pay_q[58:43] == 16'hFFFF) &&
                       (pay_q[63:60] == 4'h0) &&
                       (pay_q[42:12] == 31'h0) &&
                       (pay_q[10:8] == 3'h0) &&
                       (pay_q[5:1] == 5'h0);
            dec_ok   = pad_ok || (CHECK_PAD == 0);
        end else if (ten_q && (tst_q == 2'd0 || tst_q == 2'd2)) begin
            dec_data = pay_q[63:48];
            pad_ok   = (pay_q[47:0] == 48'h0);
            dec_ok   = pad_ok || (CHECK_PAD == 0);
        end else if (ten_q) begin
            dec_ok   = 1'b0;
        end else if (st_q == 4'd3 && sub_q == 4'd0) begin
            dec_data = {5'b0, pay_q[63:53]};
            pad_ok   = (pay_q[52:0] == 53'h0);
            dec_ok   = pad_ok || (CHECK_PAD == 0);
        end else if (st_q == 4'd3 && sub_q == 4'd4) begin
            dec_data = pay_q[63:48];
            pad_ok   = (pay_q[47:0] == 48'h0);
            dec_ok   = pad_ok || (CHECK_PAD == 0);
        end
    end

    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        st_d    = st_q;
        sub_d   = sub_q;
        cmsg_d  = cmsg_q;
        ten_d   = ten_q;
        tst_d   = tst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        msg_d   = msg_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        fmt_d   = 1'b0;
        to_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pkt) state_d = S_DECODE;
            end
            S_DECODE: begin
                ovr_d = pkt;
                if (dec_ok) begin
                    data_d  = dec_data;
                    msg_d   = cmsg_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    fmt_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (i_data_ack) begin
                    valid_d = 1'b0;
                    state_d = pkt ? S_DECODE : S_IDLE;
                end else begin
                    ovr_d = pkt;
                    cnt_d = cnt_q + 1'b1;
                    if (to_hit) begin
                        valid_d = 1'b0;
                        to_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc) begin
            pay_d  = i_payload;
            st_d   = i_state;
            sub_d  = i_sub_state;
            cmsg_d = i_msg_no;
            ten_d  = i_point_sweep_test_en;
            tst_d  = i_point_sweep_test;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pay_q   <= '0;
            st_q    <= '0;
            sub_q   <= '0;
            cmsg_q  <= '0;
            ten_q   <= 1'b0;
            tst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            fmt_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            st_q    <= st_d;
            sub_q   <= sub_d;
            cmsg_q  <= cmsg_d;
            ten_q   <= ten_d;
            tst_q   <= tst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            fmt_q   <= fmt_d;
            to_q    <= to_d;
        end
    end

    assign o_data_bus   = data_q;
    assign o_data_valid = valid_q;
    assign o_msg_no     = msg_q;
    assign o_overrun    = ovr_q;
    assign o_fmt_err    = fmt_q;
    assign o_timeout    = to_q;

endmodule
